// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM encoding and counter-width helper for the button gesture classifier.
package btn_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRESS1    = 3'd1,
      WAIT_GAP  = 3'd2,
      PRESS2    = 3'd3,
      LONG_HELD = 3'd4
   } state_t;

   function automatic int calc_w(input int long_cycles, input int gap_cycles);
      return $clog2(long_cycles > gap_cycles ? long_cycles : gap_cycles) + 1;
   endfunction

endpackage

// File: rtl/edge_detector.sv
// edge_detector: registers a clk-synchronous level and flags its rising and falling edges combinationally.
module edge_detector (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);

   logic prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) prev_q <= 1'b0;
      else         prev_q <= d_i;
   end

   assign rise_o = d_i & ~prev_q;
   assign fall_o = ~d_i & prev_q;

endmodule

// File: rtl/button_event_classifier.sv
// button_event_classifier: turns a debounced button level into one-cycle press/release/click/double/long events.
module button_event_classifier
   import btn_pkg::*;
#(
   parameter int LONG_CYCLES = 50_000_000,
   parameter int GAP_CYCLES  = 12_500_000,
   parameter int W           = calc_w(LONG_CYCLES, GAP_CYCLES)
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic button_i,
   output logic press_o,
   output logic release_o,
   output logic short_click_o,
   output logic double_click_o,
   output logic long_press_o,
   output logic held_long_o
);

   localparam logic [W-1:0] LONG_LAST = W'(LONG_CYCLES - 1);
   localparam logic [W-1:0] GAP_LAST  = W'(GAP_CYCLES - 1);

   logic rise, fall;
   state_t state_q, state_d;
   logic [W-1:0] cnt_q, cnt_d;
   logic short_d, double_d, long_d;

   edge_detector u_edge (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .d_i   (button_i),
      .rise_o(rise),
      .fall_o(fall)
   );

   // Counter defaults to counting; every state change clears it explicitly.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 1'b1;
      short_d  = 1'b0;
      double_d = 1'b0;
      long_d   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (rise) state_d = PRESS1;
         end
         PRESS1: begin
            if (fall) begin
               state_d = WAIT_GAP;
               cnt_d   = '0;
            end else if (cnt_q == LONG_LAST) begin
               state_d = LONG_HELD;
               cnt_d   = '0;
               long_d  = 1'b1;
            end
         end
         WAIT_GAP: begin
            if (rise) begin
               state_d = PRESS2;
               cnt_d   = '0;
            end else if (cnt_q == GAP_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               short_d = 1'b1;
            end
         end
         PRESS2: begin
            if (fall) begin
               state_d  = IDLE;
               cnt_d    = '0;
               double_d = 1'b1;
            end else if (cnt_q == LONG_LAST) begin
               state_d = LONG_HELD;
               cnt_d   = '0;
               long_d  = 1'b1;
            end
         end
         LONG_HELD: begin
            cnt_d = '0;
            if (fall) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         press_o        <= 1'b0;
         release_o      <= 1'b0;
         short_click_o  <= 1'b0;
         double_click_o <= 1'b0;
         long_press_o   <= 1'b0;
         held_long_o    <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         press_o        <= rise;
         release_o      <= fall;
         short_click_o  <= short_d;
         double_click_o <= double_d;
         long_press_o   <= long_d;
         held_long_o    <= (state_d == LONG_HELD);
      end
   end

endmodule

// File: tb/tb_button_event_classifier.sv
// tb_button_event_classifier: directed gesture sequences with hand-computed per-cycle event vectors.
module tb_button_event_classifier;

   localparam logic [5:0] NONE = 6'b000000;
   localparam logic [5:0] PR   = 6'b100000;
   localparam logic [5:0] RL   = 6'b010000;
   localparam logic [5:0] SC   = 6'b001000;
   localparam logic [5:0] DC   = 6'b000100;
   localparam logic [5:0] LP   = 6'b000010;
   localparam logic [5:0] HL   = 6'b000001;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   logic button = 1'b0;
   logic press, rel, sc, dc, lp, hl;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   button_event_classifier #(.LONG_CYCLES(10), .GAP_CYCLES(5)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .button_i      (button),
      .press_o       (press),
      .release_o     (rel),
      .short_click_o (sc),
      .double_click_o(dc),
      .long_press_o  (lp),
      .held_long_o   (hl)
   );

   // Observed vector order: {press, release, short_click, double_click, long_press, held_long}.
   task automatic chk(input string tag, input logic [5:0] exp);
      checks++;
      assert ({press, rel, sc, dc, lp, hl} === exp)
      else begin
         errors++;
         $error("FAIL %s: got %b expected %b", tag, {press, rel, sc, dc, lp, hl}, exp);
      end
   endtask

   task automatic cyc(input logic b, input logic [5:0] exp, input string tag);
      button = b;
      @(posedge clk);
      #1;
      chk(tag, exp);
   endtask

   initial begin
      for (int i = 0; i < 6; i++) cyc(i[0], NONE, "reset_hold");
      button = 1'b0;
      #2 rst_ni = 1'b1;
      repeat (8) cyc(0, NONE, "idle_after_reset");

      cyc(1, PR, "sc_press");
      repeat (2) cyc(1, NONE, "sc_hold");
      cyc(0, RL, "sc_release");
      repeat (4) cyc(0, NONE, "sc_gap");
      cyc(0, SC, "sc_pulse");
      repeat (3) cyc(0, NONE, "sc_after");

      cyc(1, PR, "dc_press1");
      repeat (2) cyc(1, NONE, "dc_hold1");
      cyc(0, RL, "dc_release1");
      cyc(0, NONE, "dc_gap");
      cyc(1, PR, "dc_press2");
      repeat (2) cyc(1, NONE, "dc_hold2");
      cyc(0, RL | DC, "dc_release2");
      repeat (6) cyc(0, NONE, "dc_after");

      cyc(1, PR, "lp_press");
      repeat (9) cyc(1, NONE, "lp_hold");
      cyc(1, LP | HL, "lp_pulse");
      repeat (4) cyc(1, HL, "lp_held");
      cyc(0, RL, "lp_release");
      repeat (6) cyc(0, NONE, "lp_after");

      cyc(1, PR, "gb_press1");
      repeat (2) cyc(1, NONE, "gb_hold1");
      cyc(0, RL, "gb_release1");
      repeat (4) cyc(0, NONE, "gb_gap");
      cyc(1, PR, "gb_rise_at_expiry");
      repeat (2) cyc(1, NONE, "gb_hold2");
      cyc(0, RL | DC, "gb_double");
      repeat (6) cyc(0, NONE, "gb_after");

      cyc(1, PR, "gl_press1");
      repeat (2) cyc(1, NONE, "gl_hold1");
      cyc(0, RL, "gl_release1");
      repeat (4) cyc(0, NONE, "gl_gap");
      cyc(0, SC, "gl_short");
      cyc(1, PR, "gl_new_press");
      repeat (2) cyc(1, NONE, "gl_new_hold");
      cyc(0, RL, "gl_new_release");
      repeat (4) cyc(0, NONE, "gl_new_gap");
      cyc(0, SC, "gl_short2");
      repeat (2) cyc(0, NONE, "gl_after");

      cyc(1, PR, "mr_press1");
      repeat (2) cyc(1, NONE, "mr_hold1");
      cyc(0, RL, "mr_release1");
      cyc(0, NONE, "mr_gap");
      cyc(1, PR, "mr_press2");
      repeat (3) cyc(1, NONE, "mr_hold2");
      rst_ni = 1'b0;
      #1 chk("mr_async", NONE);
      repeat (2) cyc(0, NONE, "mr_in_reset");
      #2 rst_ni = 1'b1;
      repeat (8) cyc(0, NONE, "mr_after");

      cyc(1, PR, "lh_press");
      repeat (9) cyc(1, NONE, "lh_hold");
      cyc(1, LP | HL, "lh_pulse");
      repeat (2) cyc(1, HL, "lh_held");
      rst_ni = 1'b0;
      #1 chk("lh_async", NONE);
      cyc(1, NONE, "lh_in_reset");
      #2 rst_ni = 1'b1;
      cyc(1, PR, "rr_press");
      cyc(1, NONE, "rr_hold");
      cyc(0, RL, "rr_release");
      repeat (4) cyc(0, NONE, "rr_gap");
      cyc(0, SC, "rr_short");
      repeat (2) cyc(0, NONE, "rr_after");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
